// File: rtl/simd_add_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_add_arbiter_if
// Description : Requester-side bundle for the shared SIMD adder arbiter.
//               Carries the per-requester operand handshake (req_*) and the
//               per-requester result handshake (rsp_*). Operand buses hold
//               requester i at slice i; rsp_z is shared and is qualified by
//               the one-hot rsp_valid.
//   master : requester side (drives req_valid/req_a/req_b/rsp_ready)
//   slave  : arbiter side   (drives req_ready/rsp_valid/rsp_z)
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LANE_W  = 10
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*4*LANE_W-1:0] req_a;
    logic [NUM_REQ*4*LANE_W-1:0] req_b;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [4*LANE_W-1:0]         rsp_z;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z
    );
endinterface
`default_nettype wire

// File: rtl/simd_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : simd_add_arbiter
// Description : Round-robin arbiter/sequencer sharing one 4-lane SIMD adder
//               (fixed LATENCY start-to-done, clock-enable stall) among
//               NUM_REQ requesters. A tag pipeline tracks the requester ID of
//               every in-flight operation so each result is steered back to
//               its issuer; an unaccepted result freezes the whole pipeline
//               (adder included) through add_ce.
// Ports       :
//   ap_clk, ap_rst_n  clock / synchronous active-low reset
//   issue_en          1 = grants allowed, 0 = drain only
//   rq (slave)        requester operand + result handshakes
//   add_rst/ce/start  adder control (add_rst = ~ap_rst_n)
//   add_a, add_b      adder operands (zero when nothing is granted)
//   add_done, add_z   adder result
//   busy              any operation in flight
//   err_sync          sticky: add_done disagreed with tag pipeline output
// Revision    : 1.0 - initial release
// ============================================================================
module simd_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LANE_W  = 10,
    parameter int LATENCY = 2
) (
    input  wire                   ap_clk,
    input  wire                   ap_rst_n,
    input  wire                   issue_en,
    simd_add_arbiter_if.slave     rq,
    output logic                  add_rst,
    output logic                  add_ce,
    output logic                  add_start,
    output logic [4*LANE_W-1:0]   add_a,
    output logic [4*LANE_W-1:0]   add_b,
    input  wire                   add_done,
    input  wire  [4*LANE_W-1:0]   add_z,
    output logic                  busy,
    output logic                  err_sync
);
    localparam int c_DW   = 4 * LANE_W;
    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tag pipeline: stage k mirrors adder pipeline position k
    logic [LATENCY-1:0] r_stg_vld;
    logic [c_ID_W-1:0]  r_stg_id [LATENCY];
    logic [c_ID_W-1:0]  r_last_grant;
    logic               r_err_sync;

    logic               w_out_vld;
    logic [c_ID_W-1:0]  w_out_id;
    logic               w_stall;
    logic               w_gnt_found;
    logic [c_ID_W-1:0]  w_gnt_id;
    logic               w_grant;

    assign w_out_vld = r_stg_vld[LATENCY-1];
    assign w_out_id  = r_stg_id[LATENCY-1];

    // Output stage holding a result its owner will not take this cycle
    assign w_stall   = w_out_vld & ~rq.rsp_ready[w_out_id];

    assign add_rst   = ~ap_rst_n;
    // Forced high in reset so the adder's own reset is always clocked in
    assign add_ce    = ~ap_rst_n | ~w_stall;
    assign busy      = ap_rst_n & (|r_stg_vld);
    assign err_sync  = r_err_sync;
    assign rq.rsp_z  = add_z;

    // Round-robin search: first pass looks strictly above last_grant,
    // second pass wraps around to requesters at or below it.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_found && rq.req_valid[i] && (c_ID_W'(i) > r_last_grant)) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = c_ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_found && rq.req_valid[i] && (c_ID_W'(i) <= r_last_grant)) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = c_ID_W'(i);
            end
        end
    end

    assign w_grant   = ap_rst_n & add_ce & issue_en & w_gnt_found;
    assign add_start = w_grant;

    // Grant one-hot, operand routing and response steering
    always_comb begin
        rq.req_ready = '0;
        rq.rsp_valid = '0;
        add_a        = '0;
        add_b        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_gnt_id == c_ID_W'(i))) begin
                rq.req_ready[i] = 1'b1;
                add_a           = rq.req_a[i*c_DW +: c_DW];
                add_b           = rq.req_b[i*c_DW +: c_DW];
            end
            if (ap_rst_n && w_out_vld && (w_out_id == c_ID_W'(i))) begin
                rq.rsp_valid[i] = 1'b1;
            end
        end
    end

    // Tag pipeline advances in lock-step with the adder clock enable
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stg_vld[k] <= 1'b0;
                r_stg_id[k]  <= '0;
            end
        end else if (add_ce) begin
            r_stg_vld[0] <= w_grant;
            r_stg_id[0]  <= w_gnt_id;
            for (int k = 1; k < LATENCY; k++) begin
                r_stg_vld[k] <= r_stg_vld[k-1];
                r_stg_id[k]  <= r_stg_id[k-1];
            end
        end
    end

    // Arbitration pointer; reset value makes requester 0 win first
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_last_grant <= w_gnt_id;
        end
    end

    // Checked every cycle, stalls included: a frozen adder must keep
    // add_done asserted while the output stage holds a valid tag.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_err_sync <= 1'b0;
        end else if (add_done != w_out_vld) begin
            r_err_sync <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_simd_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_add_arbiter
// Description : Self-checking bench for simd_add_arbiter with a behavioural
//               2-cycle clock-enabled 4-lane adder. Cycle table for fairness,
//               single op, backpressure, wrap-around and issue_en drain, plus
//               hand sequences for reset mid-flight and sync error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_add_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LANE_W  = 10;
    localparam int LATENCY = 2;
    localparam int DW      = 4 * LANE_W;
    localparam int NROWS   = 28;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          issue_en = 1'b0;
    logic          add_rst, add_ce, add_start, add_done, busy, err_sync;
    logic [DW-1:0] add_a, add_b, add_z;

    simd_add_arbiter_if #(.NUM_REQ(NUM_REQ), .LANE_W(LANE_W)) rq ();

    simd_add_arbiter #(.NUM_REQ(NUM_REQ), .LANE_W(LANE_W), .LATENCY(LATENCY)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .issue_en  (issue_en),
        .rq        (rq.slave),
        .add_rst   (add_rst),
        .add_ce    (add_ce),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_z     (add_z),
        .busy      (busy),
        .err_sync  (err_sync)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- behavioural adder ----------------
    logic          m1_v = 1'b0, m2_v = 1'b0, force_done = 1'b0;
    logic [DW-1:0] m1_z = '0, m2_z = '0;

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int l = 0; l < 4; l++) r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
        return r;
    endfunction

    always @(posedge ap_clk) begin
        if (add_rst) begin
            m1_v <= 1'b0; m2_v <= 1'b0; m1_z <= '0; m2_z <= '0;
        end else if (add_ce) begin
            m1_v <= add_start;
            m1_z <= lane_add(add_a, add_b);
            m2_v <= m1_v;
            m2_z <= m1_z;
        end
    end
    assign add_done = m2_v | force_done;
    assign add_z    = m2_z;

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {LANE_W'(l3), LANE_W'(l2), LANE_W'(l1), LANE_W'(l0)};
    endfunction

    typedef struct {
        logic          ie;
        logic [3:0]    rv;
        logic [3:0]    rr;
        logic [3:0]    x_ready;
        logic [3:0]    x_rsp;
        logic [DW-1:0] x_z;
        logic          x_ce;
        logic          x_busy;
    } vec_t;

    function automatic vec_t mk(input logic ie, input logic [3:0] rv, input logic [3:0] rr,
                                input logic [3:0] xr, input logic [3:0] xs, input logic [DW-1:0] xz,
                                input logic xc, input logic xb);
        vec_t v;
        v.ie = ie; v.rv = rv; v.rr = rr; v.x_ready = xr; v.x_rsp = xs;
        v.x_z = xz; v.x_ce = xc; v.x_busy = xb;
        return v;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge ap_clk);
    endtask

    vec_t          tbl [NROWS];
    logic [DW-1:0] s0, s1, s2, s3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Expected sums, computed by hand per lane (mod 1024)
        s0 = pk(11, 22, 33, 44);
        s1 = pk(111, 122, 133, 144);
        s2 = pk(211, 222, 233, 244);
        s3 = pk(0, 0, 0, 1022);   // 1023+1, 512+512, 0+0, 1023+1023

        rq.req_valid = '0;
        rq.rsp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            rq.req_a[i*DW +: DW] = pk(100*i+1, 100*i+2, 100*i+3, 100*i+4);
            rq.req_b[i*DW +: DW] = pk(10, 20, 30, 40);
        end
        rq.req_a[3*DW +: DW] = pk(1023, 512, 0, 1023);
        rq.req_b[3*DW +: DW] = pk(1, 512, 0, 1023);

        //                ie  rv    rr    ready  rsp   z     ce  busy
        // fairness: all four requesting, grants 0,1,2,3,0,1,2,3
        tbl[0]  = mk(1, 4'hF, 4'hF, 4'h1, 4'h0, '0, 1, 0);
        tbl[1]  = mk(1, 4'hF, 4'hF, 4'h2, 4'h0, '0, 1, 1);
        tbl[2]  = mk(1, 4'hF, 4'hF, 4'h4, 4'h1, s0, 1, 1);
        tbl[3]  = mk(1, 4'hF, 4'hF, 4'h8, 4'h2, s1, 1, 1);
        tbl[4]  = mk(1, 4'hF, 4'hF, 4'h1, 4'h4, s2, 1, 1);
        tbl[5]  = mk(1, 4'hF, 4'hF, 4'h2, 4'h8, s3, 1, 1);
        tbl[6]  = mk(1, 4'hF, 4'hF, 4'h4, 4'h1, s0, 1, 1);
        tbl[7]  = mk(1, 4'hF, 4'hF, 4'h8, 4'h2, s1, 1, 1);
        tbl[8]  = mk(1, 4'h0, 4'hF, 4'h0, 4'h4, s2, 1, 1);
        tbl[9]  = mk(1, 4'h0, 4'hF, 4'h0, 4'h8, s3, 1, 1);
        tbl[10] = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 0);
        // single op from requester 0
        tbl[11] = mk(1, 4'h1, 4'hF, 4'h1, 4'h0, '0, 1, 0);
        tbl[12] = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 1);
        tbl[13] = mk(1, 4'h0, 4'hF, 4'h0, 4'h1, s0, 1, 1);
        tbl[14] = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 0);
        // backpressure: two ops from req 1, rsp_ready[1] low for 3 cycles
        tbl[15] = mk(1, 4'h2, 4'hF, 4'h2, 4'h0, '0, 1, 0);
        tbl[16] = mk(1, 4'h2, 4'hF, 4'h2, 4'h0, '0, 1, 1);
        tbl[17] = mk(1, 4'h1, 4'hD, 4'h0, 4'h2, s1, 0, 1);
        tbl[18] = mk(1, 4'h1, 4'hD, 4'h0, 4'h2, s1, 0, 1);
        tbl[19] = mk(1, 4'h1, 4'hD, 4'h0, 4'h2, s1, 0, 1);
        tbl[20] = mk(1, 4'h1, 4'hF, 4'h1, 4'h2, s1, 1, 1);  // accept + grant same cycle
        tbl[21] = mk(1, 4'h0, 4'hF, 4'h0, 4'h2, s1, 1, 1);
        tbl[22] = mk(1, 4'h0, 4'hF, 4'h0, 4'h1, s0, 1, 1);
        tbl[23] = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, '0, 1, 0);
        // issue_en low: in-flight op drains, no new grants
        tbl[24] = mk(1, 4'h4, 4'hF, 4'h4, 4'h0, '0, 1, 0);
        tbl[25] = mk(0, 4'hF, 4'hF, 4'h0, 4'h0, '0, 1, 1);
        tbl[26] = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, s2, 1, 1);
        tbl[27] = mk(0, 4'hF, 4'hF, 4'h0, 4'h0, '0, 1, 0);

        // ---------------- reset state ----------------
        cyc(); #1;
        chk("rst req_ready", 64'(rq.req_ready), 64'h0);
        chk("rst rsp_valid", 64'(rq.rsp_valid), 64'h0);
        chk("rst add_start", 64'(add_start), 64'h0);
        chk("rst add_ce",    64'(add_ce), 64'h1);
        chk("rst add_rst",   64'(add_rst), 64'h1);
        chk("rst busy",      64'(busy), 64'h0);
        cyc(); ap_rst_n = 1'b1; #1;
        chk("post-rst err_sync", 64'(err_sync), 64'h0);
        chk("post-rst add_rst",  64'(add_rst), 64'h0);

        // ---------------- table ----------------
        for (int r = 0; r < NROWS; r++) begin
            cyc();
            issue_en     = tbl[r].ie;
            rq.req_valid = tbl[r].rv;
            rq.rsp_ready = tbl[r].rr;
            #1;
            chk($sformatf("row%0d req_ready", r), 64'(rq.req_ready), 64'(tbl[r].x_ready));
            chk($sformatf("row%0d add_start", r), 64'(add_start), 64'(tbl[r].x_ready != 4'h0));
            chk($sformatf("row%0d rsp_valid", r), 64'(rq.rsp_valid), 64'(tbl[r].x_rsp));
            chk($sformatf("row%0d add_ce", r),    64'(add_ce), 64'(tbl[r].x_ce));
            chk($sformatf("row%0d busy", r),      64'(busy), 64'(tbl[r].x_busy));
            if (tbl[r].x_rsp != 4'h0)
                chk($sformatf("row%0d rsp_z", r), 64'(rq.rsp_z), 64'(tbl[r].x_z));
        end
        chk("table err_sync", 64'(err_sync), 64'h0);

        // ---------------- reset mid-flight ----------------
        cyc(); issue_en = 1'b1; rq.req_valid = 4'h1; rq.rsp_ready = 4'hF; #1;
        chk("midrst grant", 64'(rq.req_ready), 64'h1);
        cyc(); ap_rst_n = 1'b0; rq.req_valid = 4'h0; #1;
        chk("midrst req_ready", 64'(rq.req_ready), 64'h0);
        chk("midrst add_ce",    64'(add_ce), 64'h1);
        chk("midrst add_rst",   64'(add_rst), 64'h1);
        chk("midrst busy",      64'(busy), 64'h0);
        chk("midrst rsp_valid", 64'(rq.rsp_valid), 64'h0);
        cyc(); ap_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("midrst drop%0d rsp_valid", k), 64'(rq.rsp_valid), 64'h0);
            chk($sformatf("midrst drop%0d busy", k),      64'(busy), 64'h0);
            cyc();
        end
        rq.req_valid = 4'hF; #1;
        chk("midrst last_grant reset", 64'(rq.req_ready), 64'h1);
        cyc(); rq.req_valid = 4'h0;
        cyc(); #1;
        chk("midrst new rsp_valid", 64'(rq.rsp_valid), 64'h1);
        chk("midrst new rsp_z",     64'(rq.rsp_z), 64'(s0));
        chk("midrst err_sync",      64'(err_sync), 64'h0);

        // ---------------- sync error ----------------
        cyc(); #1;
        chk("sync idle busy", 64'(busy), 64'h0);
        cyc(); force_done = 1'b1; #1;
        chk("sync err before", 64'(err_sync), 64'h0);
        cyc(); force_done = 1'b0; #1;
        chk("sync err set", 64'(err_sync), 64'h1);
        cyc(); cyc(); #1;
        chk("sync err sticky", 64'(err_sync), 64'h1);
        cyc(); ap_rst_n = 1'b0;
        cyc(); ap_rst_n = 1'b1; #1;
        chk("sync err cleared", 64'(err_sync), 64'h0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
